// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, ALU opcodes, forwarding
// selects and the EX/MEM pipeline bundle.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'hA,
    ALU_SLTU = 4'hB
  } aluop_t;

  typedef enum logic [1:0] {
    FWD_RAW = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  // Contents of the EX/MEM pipeline register.
  typedef struct packed {
    word_t    alu_result;
    word_t    store_data;
    regbits_t write_reg;
    logic     reg_wen;
    logic     mem_to_reg;
    logic     dmem_wen;
    logic     dmem_ren;
    logic     halt;
    word_t    pcplus4;
    logic     overflow;
  } exmem_t;

  // Chooses the operand source for one source register. MEM is the younger
  // producer, so it beats WB; register 0 is hard-wired and never forwarded.
  function automatic fwd_sel_t fwd_pick(
    input logic     fwd_en,
    input regbits_t rsel,
    input logic     mem_wen,
    input regbits_t mem_wr,
    input logic     wb_wen,
    input regbits_t wb_wr
  );
    fwd_sel_t sel;
    sel = FWD_RAW;
    if (!fwd_en || (rsel == 5'd0)) begin
      sel = FWD_RAW;
    end else if (mem_wen && (mem_wr == rsel)) begin
      sel = FWD_MEM;
    end else if (wb_wen && (wb_wr == rsel)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RAW;
    end
    return sel;
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational ALU. Shifts use b[4:0] as the amount; SLT is signed,
// SLTU unsigned; overflow is reported only for ADD and SUB.
module alu
  import cpu_types_pkg::*;
(
  input  word_t  a,
  input  word_t  b,
  input  aluop_t op,
  output word_t  result,
  output logic   zero,
  output logic   overflow
);

  logic [4:0] shamt_s;
  word_t      sum_s;
  word_t      diff_s;

  assign shamt_s = b[4:0];
  assign sum_s   = a + b;
  assign diff_s  = a - b;

  // Operation select and signed-overflow detection.
  always_comb begin
    result   = 32'd0;
    overflow = 1'b0;
    case (op)
      ALU_SLL:  result = a << shamt_s;
      ALU_SRL:  result = a >> shamt_s;
      ALU_ADD: begin
        result   = sum_s;
        overflow = (a[31] == b[31]) && (sum_s[31] != a[31]);
      end
      ALU_SUB: begin
        result   = diff_s;
        overflow = (a[31] != b[31]) && (diff_s[31] != a[31]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
      default: begin
        result   = 32'd0;
        overflow = 1'b0;
      end
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding from MEM/WB, ALU, branch/JR resolution
// and the EX/MEM pipeline register. Redirect is combinational and is not
// qualified by the latch enable; hazard logic is expected to do that.
module ex_stage
  import cpu_types_pkg::*;
#(
  parameter bit          FWD_EN   = 1'b1,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic     CLK,
  input  logic     nRST,
  input  word_t    rdat1,
  input  word_t    rdat2,
  input  word_t    immext,
  input  word_t    pcplus4,
  input  regbits_t rsel1,
  input  regbits_t rsel2,
  input  regbits_t writeReg,
  input  aluop_t   AluOp,
  input  logic     AluSrc,
  input  logic     MemToReg,
  input  logic     regWEN,
  input  logic     dMemWEN,
  input  logic     dMemREN,
  input  logic     Halt,
  input  logic     beq,
  input  logic     bne,
  input  logic     jr,
  input  logic     mem_regWEN,
  input  regbits_t mem_writeReg,
  input  word_t    mem_result,
  input  logic     wb_regWEN,
  input  regbits_t wb_writeReg,
  input  word_t    wb_result,
  input  logic     exmem_writeEN,
  input  logic     exmem_flush,
  output logic     redirect,
  output word_t    redirect_pc,
  output word_t    exm_aluResult,
  output word_t    exm_storeData,
  output regbits_t exm_writeReg,
  output logic     exm_regWEN,
  output logic     exm_MemToReg,
  output logic     exm_dMemWEN,
  output logic     exm_dMemREN,
  output logic     exm_Halt,
  output word_t    exm_pcplus4,
  output logic     exm_overflow
);

  fwd_sel_t sel_a_s;
  fwd_sel_t sel_b_s;
  word_t    fwd_a_s;
  word_t    fwd_b_s;
  word_t    alu_b_s;
  word_t    alu_result_s;
  logic     alu_overflow_s;
  logic     unused_alu_zero_s;
  word_t    br_target_s;
  logic     br_taken_s;
  exmem_t   exm_r;
  exmem_t   exm_next_s;

  assign sel_a_s = fwd_pick(FWD_EN, rsel1, mem_regWEN, mem_writeReg, wb_regWEN, wb_writeReg);
  assign sel_b_s = fwd_pick(FWD_EN, rsel2, mem_regWEN, mem_writeReg, wb_regWEN, wb_writeReg);

  // Operand A source mux.
  always_comb begin
    fwd_a_s = rdat1;
    case (sel_a_s)
      FWD_MEM: fwd_a_s = mem_result;
      FWD_WB:  fwd_a_s = wb_result;
      default: fwd_a_s = rdat1;
    endcase
  end

  // Operand B source mux.
  always_comb begin
    fwd_b_s = rdat2;
    case (sel_b_s)
      FWD_MEM: fwd_b_s = mem_result;
      FWD_WB:  fwd_b_s = wb_result;
      default: fwd_b_s = rdat2;
    endcase
  end

  assign alu_b_s = AluSrc ? immext : fwd_b_s;

  alu u_alu (
    .a        (fwd_a_s),
    .b        (alu_b_s),
    .op       (AluOp),
    .result   (alu_result_s),
    .zero     (unused_alu_zero_s),
    .overflow (alu_overflow_s)
  );

  // Branch comparison uses the forwarded register values, never the immediate.
  assign br_target_s = pcplus4 + (immext << BR_SHIFT);
  assign br_taken_s  = (beq && (fwd_a_s == fwd_b_s)) || (bne && (fwd_a_s != fwd_b_s));

  // Redirect decision; JR takes precedence over any branch flag.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = pcplus4;
    if (jr) begin
      redirect    = 1'b1;
      redirect_pc = fwd_a_s;
    end else if (br_taken_s) begin
      redirect    = 1'b1;
      redirect_pc = br_target_s;
    end else begin
      redirect    = 1'b0;
      redirect_pc = pcplus4;
    end
  end

  // EX/MEM next state: flush > load > hold; Halt is sticky in every case.
  always_comb begin
    exm_next_s = exm_r;
    if (exmem_flush) begin
      exm_next_s      = '0;
      exm_next_s.halt = exm_r.halt;
    end else if (exmem_writeEN) begin
      exm_next_s.alu_result = alu_result_s;
      exm_next_s.store_data = fwd_b_s;
      exm_next_s.write_reg  = writeReg;
      exm_next_s.reg_wen    = regWEN;
      exm_next_s.mem_to_reg = MemToReg;
      exm_next_s.dmem_wen   = dMemWEN;
      exm_next_s.dmem_ren   = dMemREN;
      exm_next_s.halt       = exm_r.halt | Halt;
      exm_next_s.pcplus4    = pcplus4;
      exm_next_s.overflow   = alu_overflow_s;
    end else begin
      exm_next_s = exm_r;
    end
  end

  // EX/MEM register with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      exm_r <= '0;
    end else begin
      exm_r <= exm_next_s;
    end
  end

  assign exm_aluResult = exm_r.alu_result;
  assign exm_storeData = exm_r.store_data;
  assign exm_writeReg  = exm_r.write_reg;
  assign exm_regWEN    = exm_r.reg_wen;
  assign exm_MemToReg  = exm_r.mem_to_reg;
  assign exm_dMemWEN   = exm_r.dmem_wen;
  assign exm_dMemREN   = exm_r.dmem_ren;
  assign exm_Halt      = exm_r.halt;
  assign exm_pcplus4   = exm_r.pcplus4;
  assign exm_overflow  = exm_r.overflow;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: each driven cycle pushes the expected
// redirect and the expected EX/MEM contents; monitors pop and compare.
module tb_ex_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  logic [31:0] rdat1, rdat2, immext, pcplus4, mem_result, wb_result;
  logic [4:0]  rsel1, rsel2, writeReg, mem_writeReg, wb_writeReg;
  aluop_t      AluOp;
  logic AluSrc, MemToReg, regWEN, dMemWEN, dMemREN, Halt, beq, bne, jr;
  logic mem_regWEN, wb_regWEN, exmem_writeEN, exmem_flush;
  logic        redirect;
  logic [31:0] redirect_pc, exm_aluResult, exm_storeData, exm_pcplus4;
  logic [4:0]  exm_writeReg;
  logic exm_regWEN, exm_MemToReg, exm_dMemWEN, exm_dMemREN, exm_Halt, exm_overflow;

  ex_stage #(.FWD_EN(1'b1), .BR_SHIFT(2)) dut (
    .CLK(CLK), .nRST(nRST), .rdat1(rdat1), .rdat2(rdat2), .immext(immext), .pcplus4(pcplus4),
    .rsel1(rsel1), .rsel2(rsel2), .writeReg(writeReg), .AluOp(AluOp), .AluSrc(AluSrc),
    .MemToReg(MemToReg), .regWEN(regWEN), .dMemWEN(dMemWEN), .dMemREN(dMemREN), .Halt(Halt),
    .beq(beq), .bne(bne), .jr(jr), .mem_regWEN(mem_regWEN), .mem_writeReg(mem_writeReg),
    .mem_result(mem_result), .wb_regWEN(wb_regWEN), .wb_writeReg(wb_writeReg), .wb_result(wb_result),
    .exmem_writeEN(exmem_writeEN), .exmem_flush(exmem_flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .exm_aluResult(exm_aluResult), .exm_storeData(exm_storeData),
    .exm_writeReg(exm_writeReg), .exm_regWEN(exm_regWEN), .exm_MemToReg(exm_MemToReg),
    .exm_dMemWEN(exm_dMemWEN), .exm_dMemREN(exm_dMemREN), .exm_Halt(exm_Halt),
    .exm_pcplus4(exm_pcplus4), .exm_overflow(exm_overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rdat1, rdat2, imm, pc4, mres, wres;
    logic [4:0]  rs1, rs2, wr, mwr, wwr;
    aluop_t      op;
    logic alusrc, m2r, rwen, dwen, dren, halt, beq, bne, jr, mwen, wwen, wen, flush;
  } stim_t;

  typedef struct {
    logic [31:0] res, sd, pc4;
    logic [4:0]  wr;
    logic rwen, m2r, dwen, dren, halt, ovf;
  } exm_t;

  int checks = 0;
  int errors = 0;
  exm_t        model;
  exm_t        qr[$];
  logic [32:0] qc[$];
  aluop_t      ops[10] = '{ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
                           ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU};
  localparam longint S32_MAX = 64'sd2147483647;
  localparam longint S32_MIN = -64'sd2147483648;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand as the instruction should see it: newest in-flight producer wins.
  function automatic logic [31:0] m_fwd(input logic [31:0] raw, input logic [4:0] rs, input stim_t s);
    if (rs != 5'd0 && s.mwen && s.mwr == rs) return s.mres;
    if (rs != 5'd0 && s.wwen && s.wwr == rs) return s.wres;
    return raw;
  endfunction

  task automatic m_alu(input logic [31:0] a, input logic [31:0] b, input aluop_t op,
                       output logic [31:0] r, output logic ovf);
    longint wide;
    ovf = 1'b0;
    case (op)
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_ADD:  begin wide = longint'($signed(a)) + longint'($signed(b)); r = wide[31:0];
                      ovf = (wide > S32_MAX) || (wide < S32_MIN); end
      ALU_SUB:  begin wide = longint'($signed(a)) - longint'($signed(b)); r = wide[31:0];
                      ovf = (wide > S32_MAX) || (wide < S32_MIN); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      default:  r = 32'd0;
    endcase
  endtask

  function automatic stim_t bubble();
    stim_t s;
    s.rdat1 = 32'd0; s.rdat2 = 32'd0; s.imm = 32'd0; s.pc4 = 32'd0; s.mres = 32'd0; s.wres = 32'd0;
    s.rs1 = 5'd0; s.rs2 = 5'd0; s.wr = 5'd0; s.mwr = 5'd0; s.wwr = 5'd0; s.op = ALU_ADD;
    s.alusrc = 1'b0; s.m2r = 1'b0; s.rwen = 1'b0; s.dwen = 1'b0; s.dren = 1'b0; s.halt = 1'b0;
    s.beq = 1'b0; s.bne = 1'b0; s.jr = 1'b0; s.mwen = 1'b0; s.wwen = 1'b0; s.wen = 1'b1; s.flush = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = bubble();
    s.rdat1 = rand_word(); s.rdat2 = ($urandom_range(0, 3) == 0) ? s.rdat1 : rand_word();
    s.imm = rand_word(); s.pc4 = $urandom; s.mres = rand_word(); s.wres = rand_word();
    s.rs1 = 5'($urandom_range(0, 4)); s.rs2 = 5'($urandom_range(0, 4));
    s.mwr = 5'($urandom_range(0, 4)); s.wwr = 5'($urandom_range(0, 4)); s.wr = 5'($urandom);
    s.op = ops[$urandom_range(0, 9)];
    s.alusrc = 1'($urandom); s.m2r = 1'($urandom); s.rwen = 1'($urandom);
    s.dwen = 1'($urandom); s.dren = 1'($urandom); s.halt = ($urandom_range(0, 99) == 0);
    s.beq = ($urandom_range(0, 3) == 0); s.bne = ($urandom_range(0, 3) == 0);
    s.jr = ($urandom_range(0, 7) == 0); s.mwen = 1'($urandom); s.wwen = 1'($urandom);
    s.wen = ($urandom_range(0, 4) != 0); s.flush = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Drive one cycle of inputs at the falling edge and record what must follow.
  task automatic apply(input stim_t s);
    logic [31:0] a, bf, b, r, pc;
    logic ovf, rd, h;
    @(negedge CLK);
    rdat1 = s.rdat1; rdat2 = s.rdat2; immext = s.imm; pcplus4 = s.pc4;
    rsel1 = s.rs1; rsel2 = s.rs2; writeReg = s.wr; AluOp = s.op; AluSrc = s.alusrc;
    MemToReg = s.m2r; regWEN = s.rwen; dMemWEN = s.dwen; dMemREN = s.dren; Halt = s.halt;
    beq = s.beq; bne = s.bne; jr = s.jr; mem_regWEN = s.mwen; mem_writeReg = s.mwr;
    mem_result = s.mres; wb_regWEN = s.wwen; wb_writeReg = s.wwr; wb_result = s.wres;
    exmem_writeEN = s.wen; exmem_flush = s.flush;
    a  = m_fwd(s.rdat1, s.rs1, s);
    bf = m_fwd(s.rdat2, s.rs2, s);
    b  = s.alusrc ? s.imm : bf;
    m_alu(a, b, s.op, r, ovf);
    if (s.jr) begin rd = 1'b1; pc = a; end
    else if ((s.beq && a == bf) || (s.bne && a != bf)) begin rd = 1'b1; pc = s.pc4 + s.imm * 32'd4; end
    else begin rd = 1'b0; pc = s.pc4; end
    qc.push_back({rd, pc});
    if (s.flush) begin
      h = model.halt;
      model = '{res: 32'd0, sd: 32'd0, pc4: 32'd0, wr: 5'd0, rwen: 1'b0, m2r: 1'b0,
                dwen: 1'b0, dren: 1'b0, halt: h, ovf: 1'b0};
    end else if (s.wen) begin
      model.res = r; model.sd = bf; model.pc4 = s.pc4; model.wr = s.wr; model.rwen = s.rwen;
      model.m2r = s.m2r; model.dwen = s.dwen; model.dren = s.dren; model.ovf = ovf;
      model.halt = model.halt | s.halt;
    end
    qr.push_back(model);
  endtask

  task automatic clear_model();
    model = '{res: 32'd0, sd: 32'd0, pc4: 32'd0, wr: 5'd0, rwen: 1'b0, m2r: 1'b0,
              dwen: 1'b0, dren: 1'b0, halt: 1'b0, ovf: 1'b0};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu"}, exm_aluResult, 32'd0);
    check({tag, "_sd"}, exm_storeData, 32'd0);
    check({tag, "_pc4"}, exm_pcplus4, 32'd0);
    check({tag, "_ctl"}, {25'd0, exm_writeReg, exm_regWEN, exm_MemToReg},
          32'd0);
    check({tag, "_flags"}, {28'd0, exm_dMemWEN, exm_dMemREN, exm_Halt, exm_overflow}, 32'd0);
  endtask

  // Combinational redirect monitor.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge CLK); #2;
      if (qc.size() > 0) begin
        e = qc.pop_front();
        check("redirect", {31'd0, redirect}, {31'd0, e[32]});
        check("redirect_pc", redirect_pc, e[31:0]);
      end
    end
  end

  // EX/MEM register monitor.
  initial begin
    exm_t e;
    forever begin
      @(posedge CLK); #1;
      if (qr.size() > 0) begin
        e = qr.pop_front();
        check("exm_aluResult", exm_aluResult, e.res);
        check("exm_storeData", exm_storeData, e.sd);
        check("exm_pcplus4", exm_pcplus4, e.pc4);
        check("exm_writeReg", {27'd0, exm_writeReg}, {27'd0, e.wr});
        check("exm_ctl", {26'd0, exm_regWEN, exm_MemToReg, exm_dMemWEN, exm_dMemREN, exm_Halt, exm_overflow},
              {26'd0, e.rwen, e.m2r, e.dwen, e.dren, e.halt, e.ovf});
      end
    end
  end

  initial begin
    stim_t s;
    clear_model();
    nRST = 1'b0;
    s = bubble();
    rdat1 = 32'd0; rdat2 = 32'd0; immext = 32'd0; pcplus4 = 32'd0; mem_result = 32'd0; wb_result = 32'd0;
    rsel1 = 5'd0; rsel2 = 5'd0; writeReg = 5'd0; mem_writeReg = 5'd0; wb_writeReg = 5'd0; AluOp = ALU_ADD;
    AluSrc = 1'b0; MemToReg = 1'b0; regWEN = 1'b0; dMemWEN = 1'b0; dMemREN = 1'b0; Halt = 1'b0;
    beq = 1'b0; bne = 1'b0; jr = 1'b0; mem_regWEN = 1'b0; wb_regWEN = 1'b0;
    exmem_writeEN = 1'b1; exmem_flush = 1'b0;
    #23;
    check_all_zero("reset");
    check("reset_redirect", {31'd0, redirect}, 32'd0);
    nRST = 1'b1;

    // Forwarding priority: MEM beats WB for the same register.
    s = bubble(); s.rs1 = 5'd5; s.rs2 = 5'd6; s.rdat1 = 32'h1234; s.rdat2 = 32'd1;
    s.mwen = 1'b1; s.mwr = 5'd5; s.mres = 32'hAAAA; s.wwen = 1'b1; s.wwr = 5'd5; s.wres = 32'hBBBB;
    apply(s); @(posedge CLK); #2;
    check("fwd_priority", exm_aluResult, 32'h0000_AAAB);

    // Register 0 is never forwarded.
    s = bubble(); s.rs1 = 5'd0; s.mwen = 1'b1; s.mwr = 5'd0; s.mres = 32'd7;
    s.alusrc = 1'b1; s.imm = 32'd3;
    apply(s); @(posedge CLK); #2;
    check("reg0_nofwd", exm_aluResult, 32'd3);

    // Backward branch with wrap-around target.
    s = bubble(); s.beq = 1'b1; s.rs1 = 5'd1; s.rs2 = 5'd2; s.rdat1 = 32'd9; s.rdat2 = 32'd9;
    s.pc4 = 32'h100; s.imm = 32'hFFFF_FFFF;
    apply(s); #3;
    check("beq_taken", {31'd0, redirect}, 32'd1);
    check("beq_target", redirect_pc, 32'h0000_00FC);
    s.beq = 1'b0; s.bne = 1'b1;
    apply(s); #3;
    check("bne_not_taken", {31'd0, redirect}, 32'd0);
    check("bne_pc", redirect_pc, 32'h0000_0100);

    // Stall holds, flush beats stall.
    s = bubble(); s.rdat1 = 32'd10; s.rdat2 = 32'd20; s.rwen = 1'b1; s.dwen = 1'b1; s.dren = 1'b1; s.wr = 5'd3;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      s.wen = 1'b0; s.rdat1 = 32'd100 + 32'(i); s.rwen = 1'b0;
      apply(s); @(posedge CLK); #2;
      check("stall_hold_alu", exm_aluResult, 32'd30);
      check("stall_hold_wen", {31'd0, exm_regWEN}, 32'd1);
    end
    s.flush = 1'b1; s.wen = 1'b0;
    apply(s); @(posedge CLK); #2;
    check("flush_ctl", {29'd0, exm_regWEN, exm_dMemWEN, exm_dMemREN}, 32'd0);
    check("flush_alu", exm_aluResult, 32'd0);

    // Overflow flag and sticky halt.
    s = bubble(); s.rdat1 = 32'h7FFF_FFFF; s.alusrc = 1'b1; s.imm = 32'd1;
    apply(s); @(posedge CLK); #2;
    check("ovf_result", exm_aluResult, 32'h8000_0000);
    check("ovf_flag", {31'd0, exm_overflow}, 32'd1);
    s = bubble(); s.halt = 1'b1;
    apply(s);
    s = bubble(); s.flush = 1'b1;
    apply(s); @(posedge CLK); #2;
    check("halt_sticky", {31'd0, exm_Halt}, 32'd1);

    for (int i = 0; i < 400; i++) apply(rand_stim());

    // Asynchronous reset in the middle of a loading cycle.
    s = rand_stim(); s.wen = 1'b1; s.flush = 1'b0;
    apply(s);
    #3; nRST = 1'b0; #1;
    qr.delete(); clear_model();
    check_all_zero("midreset");
    check("midreset_halt", {31'd0, exm_Halt}, 32'd0);
    @(posedge CLK); #2; nRST = 1'b1;

    for (int i = 0; i < 100; i++) apply(rand_stim());
    apply(bubble());
    @(posedge CLK); #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
